// File: rtl/ps2_cmd_tx.sv
// ps2_cmd_tx: host-to-device PS/2 command transmitter.
//
// Sends one command byte to the device over the shared open-drain PS2_CLK and
// PS2_DAT lines. The sequence is: inhibit the clock, request-to-send, then
// shift out the data bits, odd parity and stop on device-generated clock
// edges. It then checks the device ACK and waits for both lines to go idle.
// The block only ever pulls a line low or releases it. The receive path
// sharing the lines sees the device reply; this block does not decode it.
//
// Ports:
//   clock     - system clock
//   reset     - synchronous, active-low reset
//   cmd_data  - command byte, captured when cmd_send is accepted in IDLE
//   cmd_send  - request strobe; ignored while busy
//   PS2_CLK   - open-drain PS/2 clock (driven 0 or Z)
//   PS2_DAT   - open-drain PS/2 data  (driven 0 or Z)
//   cmd_busy  - high in every state except IDLE
//   cmd_done  - one-cycle pulse: frame sent and ACK received
//   cmd_error - one-cycle pulse: timeout or missing ACK
module ps2_cmd_tx #(
    parameter int INHIBIT_CYCLES = 6000,    // clock-low time before RTS (>= 2)
    parameter int START_TIMEOUT  = 750000,  // wait for first device edge
    parameter int BIT_TIMEOUT    = 100000   // max gap between device edges
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_send,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       cmd_busy,
    output logic       cmd_done,
    output logic       cmd_error
);

    localparam int T_MAX_A = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
    localparam int T_MAX   = (T_MAX_A > INHIBIT_CYCLES) ? T_MAX_A : INHIBIT_CYCLES;
    localparam int TIMER_W = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_DATA,
        S_STOP,
        S_ACK,
        S_WAIT_IDLE,
        S_ERR
    } state_t;

    state_t               state, state_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [3:0]           bit_cnt, bit_cnt_n;
    logic [8:0]           shreg, shreg_n;
    logic                 clk_low_en, clk_low_n;
    logic                 dat_low_en, dat_low_n;
    logic                 done_n, error_n;

    // Line synchronizers. They reset to 1 (idle bus) so that leaving reset
    // never looks like a falling clock edge.
    logic clk_meta, clk_sync, clk_prev;
    logic dat_meta, dat_sync;
    logic clk_fall;

    // Open-drain drive: pull low or release, never drive a 1.
    assign PS2_CLK = clk_low_en ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low_en ? 1'b0 : 1'bz;

    assign cmd_busy = (state != S_IDLE);
    assign clk_fall = clk_prev & ~clk_sync;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop, whatever the order.
        if (!reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= PS2_CLK;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= PS2_DAT;
            dat_sync <= dat_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            clk_low_en <= 1'b0;
            dat_low_en <= 1'b0;
            cmd_done   <= 1'b0;
            cmd_error  <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            clk_low_en <= clk_low_n;
            dat_low_en <= dat_low_n;
            cmd_done   <= done_n;
            cmd_error  <= error_n;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves one unassigned, which would infer a latch.
        state_n   = state;
        timer_n   = timer;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        clk_low_n = clk_low_en;
        dat_low_n = dat_low_en;
        done_n    = 1'b0;
        error_n   = 1'b0;

        case (state)
            S_IDLE: begin
                clk_low_n = 1'b0;
                dat_low_n = 1'b0;
                if (cmd_send) begin
                    shreg_n   = {~^cmd_data, cmd_data};  // odd parity above data
                    timer_n   = '0;
                    bit_cnt_n = '0;
                    clk_low_n = 1'b1;
                    state_n   = S_INHIBIT;
                end
            end

            // Clock is held low for INHIBIT_CYCLES cycles in total. The last of
            // them is spent in RTS with data already low, so data falls before
            // clock is released and never sits high with the clock free.
            S_INHIBIT: begin
                if (timer == TIMER_W'(INHIBIT_CYCLES - 2)) begin
                    timer_n   = '0;
                    dat_low_n = 1'b1;
                    state_n   = S_RTS;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            S_RTS: begin
                if (clk_low_en) begin
                    clk_low_n = 1'b0;
                    timer_n   = '0;
                end else if (clk_fall) begin
                    // First device edge: present data bit 0.
                    dat_low_n = ~shreg[0];
                    shreg_n   = shreg >> 1;
                    bit_cnt_n = 4'd1;
                    timer_n   = '0;
                    state_n   = S_DATA;
                end else if (timer == TIMER_W'(START_TIMEOUT - 1)) begin
                    state_n   = S_ERR;
                    clk_low_n = 1'b0;
                    dat_low_n = 1'b0;
                    error_n   = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            S_DATA, S_STOP, S_ACK, S_WAIT_IDLE: begin
                if (state == S_WAIT_IDLE && clk_sync && dat_sync) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (state != S_WAIT_IDLE && clk_fall) begin
                    timer_n = '0;
                    case (state)
                        S_DATA: begin
                            dat_low_n = ~shreg[0];
                            shreg_n   = shreg >> 1;
                            bit_cnt_n = bit_cnt + 4'd1;
                            // Parity goes out as the ninth bit.
                            if (bit_cnt == 4'd8) state_n = S_STOP;
                        end
                        S_STOP: begin
                            dat_low_n = 1'b0;  // release: stop bit reads 1
                            state_n   = S_ACK;
                        end
                        default: begin     // S_ACK
                            if (!dat_sync) begin
                                state_n = S_WAIT_IDLE;
                            end else begin
                                state_n = S_ERR;
                                error_n = 1'b1;
                            end
                        end
                    endcase
                end else if (timer == TIMER_W'(BIT_TIMEOUT - 1)) begin
                    state_n   = S_ERR;
                    clk_low_n = 1'b0;
                    dat_low_n = 1'b0;
                    error_n   = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            S_ERR: begin
                clk_low_n = 1'b0;
                dat_low_n = 1'b0;
                state_n   = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_cmd_tx.sv
// Self-checking bench for ps2_cmd_tx. A device model clocks the bus. It
// samples the frame on its rising clock edges and optionally drives the ACK.
// The received frame is compared against the PS/2 frame built from the byte
// (start 0, data LSB first, odd parity, stop 1). Timings are scaled down.
module tb_ps2_cmd_tx;

    localparam int IC       = 40;   // INHIBIT_CYCLES
    localparam int ST       = 300;  // START_TIMEOUT
    localparam int BT       = 250;  // BIT_TIMEOUT
    localparam int HALF     = 20;   // device clock half period in cycles
    localparam int SYNC_LAT = 3;    // pin edge -> block reacts (2 sync flops + edge reg)

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_send = 1'b0;
    logic       cmd_busy, cmd_done, cmd_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    wire        ps2_clk, ps2_dat;

    // The device side of the open-drain bus plus the pull-ups.
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    ps2_cmd_tx #(
        .INHIBIT_CYCLES (IC),
        .START_TIMEOUT  (ST),
        .BIT_TIMEOUT    (BT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_data  (cmd_data),
        .cmd_send  (cmd_send),
        .PS2_CLK   (ps2_clk),
        .PS2_DAT   (ps2_dat),
        .cmd_busy  (cmd_busy),
        .cmd_done  (cmd_done),
        .cmd_error (cmd_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling clock edge.
    int   done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int   done_cyc = -1, err_cyc = -1;
    logic busy_at_done = 1'b1;
    always @(negedge clock) begin
        if (cmd_done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = cmd_busy;
        end
        if (cmd_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (cmd_done && cmd_error) both_cnt++;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference frame as the device should see it, bit 0 = start bit.
    function automatic logic [10:0] expected_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);  // make the total count of ones odd
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Issue a command and measure how long the host holds the clock low.
    // Optionally fires a second cmd_send while the first frame is busy.
    task automatic start_frame(input logic [7:0] d, input bit retrigger,
                               output int low_cnt, output int rel_cyc);
        @(negedge clock);
        cmd_data = d;
        cmd_send = 1'b1;
        @(negedge clock);
        cmd_send = 1'b0;
        cmd_data = ~d;  // later changes must not affect the frame
        check("busy after accept", cmd_busy, 1);
        low_cnt = 0;
        while (ps2_clk === 1'b0 && low_cnt < IC + 100) begin
            low_cnt++;
            if (retrigger && low_cnt == 5) begin
                cmd_data = 8'h55;
                cmd_send = 1'b1;
            end else begin
                cmd_send = 1'b0;
            end
            @(negedge clock);
        end
        cmd_send = 1'b0;
        rel_cyc = cyc;
        check("start bit low at clock release", ps2_dat, 0);
    endtask

    // Device model: n_falls clock pulses, sampling data on each rising edge.
    task automatic device_run(input int n_falls, input bit ack_low,
                              output logic [10:0] frame, output int last_fall);
        frame     = '0;
        frame[0]  = ps2_dat;
        last_fall = -1;
        for (int i = 1; i <= n_falls; i++) begin
            tick(HALF);
            dev_clk_low = 1'b1;
            last_fall   = cyc;
            tick(HALF);
            dev_clk_low = 1'b0;
            if (i <= 10) frame[i] = ps2_dat;
            if (i == 10 && ack_low) dev_dat_low = 1'b1;
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic run_good_frame(input string tag, input logic [7:0] d, input bit retrigger);
        int          low_cnt, rel_cyc, last_fall, base_d, base_e;
        logic [10:0] frame;
        base_d = done_cnt;
        base_e = err_cnt;
        start_frame(d, retrigger, low_cnt, rel_cyc);
        check({tag, " inhibit length"}, low_cnt, IC);
        device_run(11, 1'b1, frame, last_fall);
        check({tag, " frame"}, frame, expected_frame(d));
        check({tag, " parity odd"}, $countones(frame[9:1]) % 2, 1);
        repeat (60) @(negedge clock);
        check({tag, " done pulses"}, done_cnt - base_d, 1);
        check({tag, " error pulses"}, err_cnt - base_e, 0);
        check({tag, " busy at done"}, busy_at_done, 0);
        check({tag, " done after ack"}, (done_cyc > last_fall) ? 1 : 0, 1);
    endtask

    initial begin
        int          low_cnt, rel_cyc, last_fall, base_d, base_e, waited;
        logic [10:0] frame;

        // Reset state.
        repeat (3) @(negedge clock);
        check("reset busy", cmd_busy, 0);
        check("reset done", cmd_done, 0);
        check("reset error", cmd_error, 0);
        check("reset clk released", ps2_clk, 1);
        check("reset dat released", ps2_dat, 1);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Good frames: the set-LEDs command, parity corners, random bytes.
        run_good_frame("0xED", 8'hED, 1'b0);
        run_good_frame("0x00", 8'h00, 1'b0);
        run_good_frame("0x01", 8'h01, 1'b0);
        for (int k = 0; k < 3; k++) run_good_frame("random", 8'($urandom), 1'b0);

        // Device never clocks after request-to-send.
        base_d = done_cnt;
        base_e = err_cnt;
        start_frame(8'($urandom), 1'b0, low_cnt, rel_cyc);
        waited = 0;
        while (err_cnt == base_e && waited < ST + 50) begin
            @(negedge clock);
            waited++;
        end
        check("start timeout error pulses", err_cnt - base_e, 1);
        check("start timeout latency", err_cyc - rel_cyc, ST);
        @(negedge clock);
        check("start timeout clk released", ps2_clk, 1);
        check("start timeout dat released", ps2_dat, 1);
        check("start timeout no done", done_cnt - base_d, 0);

        // Device stops clocking after presenting bit 4 (fifth falling edge).
        base_d = done_cnt;
        base_e = err_cnt;
        start_frame(8'($urandom), 1'b0, low_cnt, rel_cyc);
        device_run(5, 1'b1, frame, last_fall);
        waited = 0;
        while (err_cnt == base_e && waited < BT + 50) begin
            @(negedge clock);
            waited++;
        end
        check("bit timeout error pulses", err_cnt - base_e, 1);
        check("bit timeout latency", err_cyc - last_fall, BT + SYNC_LAT);
        @(negedge clock);
        check("bit timeout clk released", ps2_clk, 1);
        check("bit timeout dat released", ps2_dat, 1);
        check("bit timeout no done", done_cnt - base_d, 0);

        // Device answers with ACK = 1.
        base_d = done_cnt;
        base_e = err_cnt;
        start_frame(8'hF4, 1'b0, low_cnt, rel_cyc);
        device_run(11, 1'b0, frame, last_fall);
        repeat (10) @(negedge clock);
        check("nack frame", frame, expected_frame(8'hF4));
        check("nack error pulses", err_cnt - base_e, 1);
        check("nack error on 11th edge", err_cyc - last_fall, SYNC_LAT);
        check("nack no done", done_cnt - base_d, 0);
        check("nack idle", cmd_busy, 0);

        // Reset in the middle of the data bits.
        base_d = done_cnt;
        base_e = err_cnt;
        start_frame(8'h3C, 1'b0, low_cnt, rel_cyc);
        device_run(4, 1'b1, frame, last_fall);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("mid reset clk released", ps2_clk, 1);
        check("mid reset dat released", ps2_dat, 1);
        check("mid reset busy", cmd_busy, 0);
        check("mid reset done", cmd_done, 0);
        check("mid reset error", cmd_error, 0);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("mid reset no pulses", (done_cnt - base_d) + (err_cnt - base_e), 0);

        // Reset command, with a second request issued while busy.
        run_good_frame("0xFF", 8'hFF, 1'b1);
        low_cnt = 0;
        repeat (2 * IC) begin
            @(negedge clock);
            if (ps2_clk !== 1'b1) low_cnt++;
        end
        check("ignored request no second frame", low_cnt, 0);
        check("ignored request idle", cmd_busy, 0);
        check("done and error never together", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
